// File: rtl/clkmon_pkg.sv
// Shared types and helpers for the slow-clock health monitor.
// State encodings are fixed so status can be probed consistently across the clock/reset block.
package clkmon_pkg;

  typedef enum logic [1:0] {
    StAcquire = 2'd0,
    StLocked  = 2'd1,
    StStuck   = 2'd2
  } state_e;

  // Written as p + tol >= exp so a tolerance larger than the period cannot underflow.
  function automatic logic period_ok(input int unsigned p, input int unsigned exp_p,
                                     input int unsigned tol);
    return (p + tol >= exp_p) && (p <= exp_p + tol);
  endfunction

endpackage

// File: rtl/sync2.sv
// Two-flop synchroniser for an asynchronous single-bit input.
// Synchronous active-high reset clears both stages to 0.
module sync2 (
  input  logic clk_i,
  input  logic rst_i,
  input  logic d_i,
  output logic q_o
);

  logic s1_q, s1_d;
  logic s2_q, s2_d;

  always_comb begin
    s1_d = d_i;
    s2_d = s1_q;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      s1_q <= 1'b0;
      s2_q <= 1'b0;
    end else begin
      s1_q <= s1_d;
      s2_q <= s2_d;
    end
  end

  assign q_o = s2_q;

endmodule

// File: rtl/clkmon.sv
// Slow-clock health monitor: edge strobes, rise-to-rise period measurement,
// lock tracking and sticky period/stuck error flags, all in the fast clock domain.
module clkmon
  import clkmon_pkg::*;
#(
  parameter int unsigned EXP_PERIOD = 8,
  parameter int unsigned TOL        = 1,
  parameter int unsigned LOCK_COUNT = 4,
  parameter int unsigned TIMEOUT    = 32,
  parameter int unsigned CNT_W      = 8
) (
  input  logic             clk_16MHz,
  input  logic             reset,
  input  logic             clk_slow,
  input  logic             err_clr,
  output logic             rise_strobe,
  output logic             fall_strobe,
  output logic [CNT_W-1:0] period,
  output logic             period_valid,
  output logic             locked,
  output logic             err_period,
  output logic             err_stuck
);

  localparam int unsigned GoodW = (LOCK_COUNT > 1) ? $clog2(LOCK_COUNT + 1) : 1;
  localparam logic [CNT_W-1:0] CntMax = {CNT_W{1'b1}};

  logic             s2;
  logic             d_q, d_d;
  logic             rise_q, rise_d;
  logic             fall_q, fall_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [CNT_W-1:0] period_q, period_d;
  logic             period_valid_q, period_valid_d;
  logic             have_ref_q, have_ref_d;
  logic [GoodW-1:0] good_cnt_q, good_cnt_d;
  logic [GoodW-1:0] good_inc;
  state_e           state_q, state_d;
  logic             locked_q, locked_d;
  logic             err_period_q, err_period_d;
  logic             err_stuck_q, err_stuck_d;
  logic             good;
  logic             perr_set;
  logic             stuck_set;

  sync2 u_sync2 (
    .clk_i (clk_16MHz),
    .rst_i (reset),
    .d_i   (clk_slow),
    .q_o   (s2)
  );

  assign good     = period_ok(32'(cnt_q), EXP_PERIOD, TOL);
  assign good_inc = good_cnt_q + GoodW'(1);

  always_comb begin
    d_d            = s2;
    rise_d         = s2 & ~d_q;
    fall_d         = ~s2 & d_q;
    cnt_d          = (cnt_q == CntMax) ? cnt_q : cnt_q + CNT_W'(1);
    period_d       = period_q;
    period_valid_d = 1'b0;
    have_ref_d     = have_ref_q;
    good_cnt_d     = good_cnt_q;
    state_d        = state_q;
    perr_set       = 1'b0;
    stuck_set      = 1'b0;

    if (rise_q) begin
      cnt_d      = CNT_W'(1);
      have_ref_d = 1'b1;
      if (state_q == StStuck) begin
        // Leaving STUCK only re-establishes the reference edge.
        state_d = StAcquire;
      end else if (have_ref_q) begin
        period_d       = cnt_q;
        period_valid_d = 1'b1;
        if (state_q == StAcquire) begin
          if (!good) begin
            good_cnt_d = '0;
          end else if (good_inc == GoodW'(LOCK_COUNT)) begin
            state_d    = StLocked;
            good_cnt_d = '0;
          end else begin
            good_cnt_d = good_inc;
          end
        end else if (!good) begin
          state_d    = StAcquire;
          good_cnt_d = '0;
          perr_set   = 1'b1;
        end
      end
    end else if (cnt_q == CNT_W'(TIMEOUT)) begin
      state_d    = StStuck;
      have_ref_d = 1'b0;
      good_cnt_d = '0;
      stuck_set  = 1'b1;
    end

    locked_d     = (state_d == StLocked);
    err_period_d = perr_set | (err_period_q & ~err_clr);
    err_stuck_d  = stuck_set | (err_stuck_q & ~err_clr);
  end

  always_ff @(posedge clk_16MHz) begin
    if (reset) begin
      d_q            <= 1'b0;
      rise_q         <= 1'b0;
      fall_q         <= 1'b0;
      cnt_q          <= '0;
      period_q       <= '0;
      period_valid_q <= 1'b0;
      have_ref_q     <= 1'b0;
      good_cnt_q     <= '0;
      state_q        <= StAcquire;
      locked_q       <= 1'b0;
      err_period_q   <= 1'b0;
      err_stuck_q    <= 1'b0;
    end else begin
      d_q            <= d_d;
      rise_q         <= rise_d;
      fall_q         <= fall_d;
      cnt_q          <= cnt_d;
      period_q       <= period_d;
      period_valid_q <= period_valid_d;
      have_ref_q     <= have_ref_d;
      good_cnt_q     <= good_cnt_d;
      state_q        <= state_d;
      locked_q       <= locked_d;
      err_period_q   <= err_period_d;
      err_stuck_q    <= err_stuck_d;
    end
  end

  assign rise_strobe  = rise_q;
  assign fall_strobe  = fall_q;
  assign period       = period_q;
  assign period_valid = period_valid_q;
  assign locked       = locked_q;
  assign err_period   = err_period_q;
  assign err_stuck    = err_stuck_q;

endmodule

// File: tb/tb_clkmon.sv
// Bench for clkmon: directed slow-clock waveforms with a scoreboard of expected
// measurements, plus a second instance with a long timeout for counter saturation.
module tb_clkmon;

  logic       clk = 1'b0;
  logic       reset;
  logic       clk_slow, err_clr;
  logic       rise_strobe, fall_strobe, period_valid, locked, err_period, err_stuck;
  logic [7:0] period;
  logic       clk_slow2, err_clr2;
  logic       rise_strobe2, fall_strobe2, period_valid2, locked2, err_period2, err_stuck2;
  logic [7:0] period2;

  typedef struct {
    logic [7:0] period;
    logic       lock;
    logic       perr;
    logic       stuck;
  } exp_t;

  exp_t exp_q[$];
  exp_t mon_e;
  int   checks = 0;
  int   errors = 0;
  int   pv2_count = 0;

  always #5 clk = ~clk;

  clkmon #(
    .EXP_PERIOD (8),
    .TOL        (1),
    .LOCK_COUNT (4),
    .TIMEOUT    (32),
    .CNT_W      (8)
  ) dut (
    .clk_16MHz    (clk),
    .reset        (reset),
    .clk_slow     (clk_slow),
    .err_clr      (err_clr),
    .rise_strobe  (rise_strobe),
    .fall_strobe  (fall_strobe),
    .period       (period),
    .period_valid (period_valid),
    .locked       (locked),
    .err_period   (err_period),
    .err_stuck    (err_stuck)
  );

  clkmon #(
    .EXP_PERIOD (8),
    .TOL        (1),
    .LOCK_COUNT (4),
    .TIMEOUT    (250),
    .CNT_W      (8)
  ) dut2 (
    .clk_16MHz    (clk),
    .reset        (reset),
    .clk_slow     (clk_slow2),
    .err_clr      (err_clr2),
    .rise_strobe  (rise_strobe2),
    .fall_strobe  (fall_strobe2),
    .period       (period2),
    .period_valid (period_valid2),
    .locked       (locked2),
    .err_period   (err_period2),
    .err_stuck    (err_stuck2)
  );

  task automatic check(input string name, input int act, input int exp_v);
    checks++;
    if (act != exp_v) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp_v, $time);
    end
  endtask

  // Scoreboard monitor: every period_valid pulse must match the oldest expectation.
  always @(negedge clk) begin
    if (!reset && period_valid) begin
      if (exp_q.size() == 0) begin
        check("unexpected period_valid", 1, 0);
      end else begin
        mon_e = exp_q.pop_front();
        check("period", int'(period), int'(mon_e.period));
        check("locked", int'(locked), int'(mon_e.lock));
        check("err_period", int'(err_period), int'(mon_e.perr));
        check("err_stuck", int'(err_stuck), int'(mon_e.stuck));
      end
    end
    if (!reset && period_valid2) pv2_count++;
  end

  // One slow-clock cycle: high for hi fast cycles, then low for lo. The rise at the
  // start reports the previous cycle's length when meas is set.
  task automatic slow(input int hi, input int lo, input bit meas, input int p,
                      input bit lk, input bit pe, input bit st, input int clr_at);
    if (meas) exp_q.push_back('{period: 8'(p), lock: lk, perr: pe, stuck: st});
    for (int i = 0; i < hi + lo; i++) begin
      @(negedge clk);
      if (hi > 0 && i == 3) check("rise_strobe latency", int'(rise_strobe), 1);
      if (hi > 0 && i == 4) check("rise_strobe width", int'(rise_strobe), 0);
      if (hi > 0 && i == hi + 3) check("fall_strobe latency", int'(fall_strobe), 1);
      clk_slow = (i < hi);
      err_clr  = (i == clr_at);
    end
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, " rise_strobe"}, int'(rise_strobe), 0);
    check({tag, " fall_strobe"}, int'(fall_strobe), 0);
    check({tag, " period"}, int'(period), 0);
    check({tag, " period_valid"}, int'(period_valid), 0);
    check({tag, " locked"}, int'(locked), 0);
    check({tag, " err_period"}, int'(err_period), 0);
    check({tag, " err_stuck"}, int'(err_stuck), 0);
  endtask

  initial begin
    reset     = 1'b1;
    clk_slow  = 1'b0;
    err_clr   = 1'b0;
    clk_slow2 = 1'b0;
    err_clr2  = 1'b0;
    repeat (3) @(negedge clk);
    check_all_zero("reset");
    reset = 1'b0;

    // Nominal 8-cycle clock: first rise only sets the reference, lock on 5th rise.
    slow(4, 4, 0, 0, 0, 0, 0, -1);
    slow(4, 4, 1, 8, 0, 0, 0, -1);
    slow(4, 4, 1, 8, 0, 0, 0, -1);
    slow(4, 4, 1, 8, 0, 0, 0, -1);
    slow(4, 4, 1, 8, 1, 0, 0, -1);
    slow(4, 4, 1, 8, 1, 0, 0, -1);
    // Tolerance edges 7 and 9 stay locked; 11 drops lock and flags err_period.
    slow(4, 3, 1, 8, 1, 0, 0, -1);
    slow(5, 4, 1, 7, 1, 0, 0, -1);
    slow(4, 7, 1, 9, 1, 0, 0, -1);
    slow(4, 4, 1, 11, 0, 1, 0, -1);
    slow(4, 4, 1, 8, 0, 1, 0, -1);
    slow(4, 4, 1, 8, 0, 1, 0, -1);
    slow(4, 4, 1, 8, 0, 1, 0, -1);
    slow(4, 4, 1, 8, 1, 1, 0, -1);
    // err_clr with no event clears; err_clr coincident with a bad judgement loses.
    slow(4, 4, 1, 8, 1, 1, 0, 5);
    slow(4, 7, 1, 8, 1, 0, 0, -1);
    slow(4, 4, 1, 11, 0, 1, 0, 3);
    slow(4, 4, 1, 8, 0, 1, 0, 5);
    slow(4, 4, 1, 8, 0, 0, 0, -1);
    slow(4, 4, 1, 8, 0, 0, 0, -1);
    slow(4, 4, 1, 8, 1, 0, 0, -1);
    slow(4, 4, 1, 8, 1, 0, 0, -1);

    // Stuck: lock holds until cnt reaches TIMEOUT, then drops with err_stuck.
    for (int j = 0; j < 40; j++) begin
      @(negedge clk);
      if (j == 27) begin
        check("pre-timeout err_stuck", int'(err_stuck), 0);
        check("pre-timeout locked", int'(locked), 1);
      end
      if (j == 28) begin
        check("timeout err_stuck", int'(err_stuck), 1);
        check("timeout locked", int'(locked), 0);
      end
      clk_slow = 1'b0;
    end

    // Resume: first rise gives no measurement, lock after five rises.
    slow(4, 4, 0, 0, 0, 0, 1, -1);
    slow(4, 4, 1, 8, 0, 0, 1, -1);
    slow(4, 4, 1, 8, 0, 0, 1, -1);
    slow(4, 4, 1, 8, 0, 0, 1, -1);
    slow(4, 4, 1, 8, 1, 0, 1, -1);
    slow(4, 4, 1, 8, 1, 0, 1, 5);
    slow(4, 4, 1, 8, 1, 0, 0, -1);
    slow(4, 4, 1, 8, 1, 0, 0, -1);

    // Single-cycle reset while locked discards all history.
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    check_all_zero("mid-run reset");
    check("scoreboard drained before reset", exp_q.size(), 0);
    reset = 1'b0;
    slow(4, 4, 0, 0, 0, 0, 0, -1);
    slow(4, 4, 1, 8, 0, 0, 0, -1);
    slow(4, 4, 1, 8, 0, 0, 0, -1);
    slow(4, 4, 1, 8, 0, 0, 0, -1);
    slow(4, 4, 1, 8, 1, 0, 0, -1);

    // Long-timeout instance: one rise, then idle past saturation.
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset     = 1'b0;
    clk_slow2 = 1'b1;
    for (int j = 1; j <= 260; j++) begin
      @(negedge clk);
      if (j == 253) check("sat pre-timeout err_stuck", int'(err_stuck2), 0);
      if (j == 254) check("sat timeout err_stuck", int'(err_stuck2), 1);
      if (j == 4) clk_slow2 = 1'b0;
    end
    err_clr2 = 1'b1;
    @(negedge clk);
    err_clr2 = 1'b0;
    @(negedge clk);
    check("sat err_clr", int'(err_stuck2), 0);
    repeat (600) @(negedge clk);
    check("sat no counter wrap", int'(err_stuck2), 0);
    check("sat locked", int'(locked2), 0);
    check("sat no period_valid", pv2_count, 0);
    check("scoreboard drained at end", exp_q.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
